// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: run controller for the decryption processor core.
//
// Samples the five mode switches and latches a job on a start request. It then
// holds the core in reset for HOLD_CYCLES cycles, releases it, and snoops the
// core's data-memory write port. The job ends in DONE once the expected
// plaintext words arrive in order inside the mode's address window. It ends in
// ERR on a bad switch setting, an out-of-order write inside the window, or a
// timeout.
//
// Parameters:
//   HOLD_CYCLES  cycles cpu_reset stays high in HOLD (>= 1)
//   TIMEOUT      maximum RUN cycles before ERR (>= 8, fits 16 bits)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        asynchronous start request (rising edge starts a job)
//   sw[4:0]      asynchronous mode switches (sw[0] = switch1 ... sw[4] = switch5)
//   MemWrite     core data-memory write strobe
//   DataAdr      core data-memory address
//   WriteData    core write data
//   cpu_reset    active-high reset to the core; low only in RUN
//   mode         latched mode (0 XOR, 1 NEG, 2 SUM)
//   key          latched XOR key {sw[0],sw[1],sw[2]}
//   busy         high in LATCH, HOLD, RUN
//   done / error high in DONE / ERR
//   word_count   accepted words of the current job
//   last_data    data of the last accepted word
//   checksum     running mod-256 sum of accepted words
//
// Optional feature macro: SEQ_CHECKSUM_EN. When it is undefined, checksum is
// tied to 0.

module decrypt_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] sw,
  input  logic       MemWrite,
  input  logic [7:0] DataAdr,
  input  logic [7:0] WriteData,
  output logic       cpu_reset,
  output logic [1:0] mode,
  output logic [2:0] key,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] word_count,
  output logic [7:0] last_data,
  output logic [7:0] checksum
);

  localparam logic [15:0] HoldLast    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StHold,
    StRun,
    StDone,
    StErr
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Two-flop synchronizers plus one extra stage for start edge detection.
  logic [4:0] r_sw_s1, r_sw_s2;
  logic       r_start_s1, r_start_s2, r_start_prev;
  logic       w_start_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1      <= 5'd0;
      r_sw_s2      <= 5'd0;
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_sw_s1      <= sw;
      r_sw_s2      <= r_sw_s1;
      r_start_s1   <= start;
      r_start_s2   <= r_start_s1;
      r_start_prev <= r_start_s2;
    end
  end

  assign w_start_pulse = r_start_s2 & ~r_start_prev;

  // Switch decode. It is used only while in LATCH.
  logic [2:0] w_sw_key;
  logic       w_dec_ok;
  logic [1:0] w_dec_mode;
  logic [2:0] w_dec_key;
  logic [7:0] w_dec_base;
  logic [2:0] w_dec_cnt;

  assign w_sw_key = {r_sw_s2[0], r_sw_s2[1], r_sw_s2[2]};

  always_comb begin
    w_dec_ok   = 1'b1;
    w_dec_mode = 2'd0;
    w_dec_key  = 3'd0;
    w_dec_base = 8'd0;
    w_dec_cnt  = 3'd0;
    case ({r_sw_s2[4], r_sw_s2[3]})
      2'b01: begin
        w_dec_mode = 2'd1;
        w_dec_base = 8'd1;
        w_dec_cnt  = 3'd4;
      end
      2'b10: begin
        w_dec_mode = 2'd2;
        w_dec_base = 8'd5;
        w_dec_cnt  = 3'd4;
      end
      2'b00: begin
        w_dec_key = w_sw_key;
        case (w_sw_key)
          3'b000: begin
            w_dec_base = 8'd9;
            w_dec_cnt  = 3'd5;
          end
          3'b010: begin
            w_dec_base = 8'd14;
            w_dec_cnt  = 3'd4;
          end
          3'b100: begin
            w_dec_base = 8'd18;
            w_dec_cnt  = 3'd4;
          end
          default: begin
            w_dec_ok  = 1'b0;
            w_dec_key = 3'd0;
          end
        endcase
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Job registers.
  logic [1:0]  r_mode;
  logic [2:0]  r_key;
  logic [7:0]  r_base;
  logic [2:0]  r_exp;
  logic [2:0]  r_word_count;
  logic [7:0]  r_last_data;
  logic [15:0] r_hold_cnt;
  logic [15:0] r_run_cnt;

  // Write-port snoop.
  logic [7:0] w_next_adr;
  logic [8:0] w_win_end;
  logic       w_in_win;
  logic       w_accept;
  logic       w_final;
  logic       w_bad_write;
  logic       w_timeout;

  assign w_next_adr  = r_base + {5'd0, r_word_count};
  assign w_win_end   = {1'b0, r_base} + {6'd0, r_exp};
  assign w_in_win    = ({1'b0, DataAdr} >= {1'b0, r_base}) && ({1'b0, DataAdr} < w_win_end);
  assign w_accept    = (r_state == StRun) && MemWrite && (DataAdr == w_next_adr);
  assign w_final     = (r_word_count == (r_exp - 3'd1));
  assign w_bad_write = MemWrite && w_in_win && (DataAdr != w_next_adr);
  assign w_timeout   = (r_run_cnt == TimeoutLast);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start_pulse) w_state_d = StLatch;
      StLatch: w_state_d = w_dec_ok ? StHold : StErr;
      StHold:  if (r_hold_cnt == HoldLast) w_state_d = StRun;
      StRun: begin
        // A final accepted write beats a timeout in the same cycle.
        if (w_accept && w_final) w_state_d = StDone;
        else if (w_bad_write)    w_state_d = StErr;
        else if (w_timeout)      w_state_d = StErr;
      end
      StDone, StErr: if (w_start_pulse) w_state_d = StLatch;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode       <= 2'd0;
      r_key        <= 3'd0;
      r_base       <= 8'd0;
      r_exp        <= 3'd0;
      r_word_count <= 3'd0;
      r_last_data  <= 8'd0;
      r_hold_cnt   <= 16'd0;
      r_run_cnt    <= 16'd0;
    end else begin
      case (r_state)
        StLatch: begin
          r_mode       <= w_dec_mode;
          r_key        <= w_dec_key;
          r_base       <= w_dec_base;
          r_exp        <= w_dec_cnt;
          r_word_count <= 3'd0;
          r_last_data  <= 8'd0;
          r_hold_cnt   <= 16'd0;
          r_run_cnt    <= 16'd0;
        end
        StHold: r_hold_cnt <= r_hold_cnt + 16'd1;
        StRun: begin
          r_run_cnt <= r_run_cnt + 16'd1;
          if (w_accept) begin
            r_word_count <= r_word_count + 3'd1;
            r_last_data  <= WriteData;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= 8'd0;
    end else if (r_state == StLatch) begin
      r_checksum <= 8'd0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + WriteData;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'd0;
`endif

  assign cpu_reset  = (r_state != StRun);
  assign busy       = (r_state == StLatch) || (r_state == StHold) || (r_state == StRun);
  assign done       = (r_state == StDone);
  assign error      = (r_state == StErr);
  assign mode       = r_mode;
  assign key        = r_key;
  assign word_count = r_word_count;
  assign last_data  = r_last_data;

endmodule

// File: doc/decrypt_sequencer.md
# decrypt_sequencer

Run controller for the decryption processor core. Samples the five mode switches, latches a decryption job on a start request, holds the core in reset for a fixed time, then releases it and monitors its data-memory write port. Signals completion once the expected plaintext words land in order at the mode's address window, or signals an error on a bad switch setting, an out-of-order write or a timeout. Sits between the board switches/start button and the core's `reset` input, snooping `MemWrite`/`DataAdr`/`WriteData`.

## Interface
- `HOLD_CYCLES`, 2: cycles `cpu_reset` stays asserted after a job is latched (≥1).
- `TIMEOUT`, 300: maximum RUN cycles before error (≥8, fits 16 bits).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: asynchronous start request; a job begins on its synchronized rising edge.
- `sw` in 5: `sw[0]`=switch1, `sw[1]`=switch2, `sw[2]`=switch3, `sw[3]`=switch4, `sw[4]`=switch5; asynchronous.
- `MemWrite` in 1: core data-memory write strobe.
- `DataAdr` in 8: core data-memory address.
- `WriteData` in 8: core write data.
- `cpu_reset` out 1: active-high reset to the core.
- `mode` out 2: latched mode; 0 XOR, 1 NEG, 2 SUM.
- `key` out 3: latched XOR key `{sw[0],sw[1],sw[2]}`; 0 for NEG/SUM.
- `busy` out 1: high in LATCH, HOLD, RUN.
- `done` out 1: high in DONE.
- `error` out 1: high in ERR.
- `word_count` out 3: accepted words of the current job.
- `last_data` out 8: `WriteData` of the last accepted word.
- `checksum` out 8: running sum of accepted words (see Configuration).

## Operation
- `sw` and `start` each pass through a 2-flop synchronizer; `start_pulse` = sync `start` high and its previous sample low.
- States: IDLE, LATCH, HOLD, RUN, DONE, ERR.
- IDLE: on `start_pulse` go to LATCH. `start_pulse` in any other state except DONE/ERR is ignored.
- LATCH: decode synced `sw`, load `mode`/`key`/base/expected count, clear `word_count`, `last_data`, `checksum`, timers.
  - sw4=1, sw5=0: NEG, base 1, 4 words.
  - sw4=0, sw5=1: SUM, base 5, 4 words.
  - sw4=0, sw5=0, key 000: XOR, base 9, 5 words; key 010: base 14, 4 words; key 100: base 18, 4 words.
  - sw4=1 and sw5=1, or any other XOR key: go to ERR; otherwise to HOLD.
- HOLD: stay `HOLD_CYCLES` cycles, then RUN.
- RUN: each cycle with `MemWrite`=1:
  - `DataAdr` == base + `word_count`: accept; `word_count`+1, `last_data`←`WriteData`, `checksum`+=`WriteData` mod 256.
  - `DataAdr` in [base, base+expected−1] but not the next address: go to ERR.
  - `DataAdr` outside the window: ignored (stack/scratch writes).
  - Accepting the final word: go to DONE.
  - `TIMEOUT` RUN cycles elapsed without completion: go to ERR.
- DONE/ERR: hold all outputs; a new `start_pulse` goes to LATCH (re-sampling `sw`).
- `cpu_reset` = 0 only in RUN; 1 in every other state.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, all other outputs 0, synchronizers cleared.
- `reset` asserted mid-job aborts immediately (asynchronously) to reset values; no partial completion is reported.
- `start` pin rise to `start_pulse`: 2–3 cycles. `start_pulse` at cycle k: LATCH k+1, HOLD from k+2, RUN from k+2+`HOLD_CYCLES` (`cpu_reset` falls at that edge).
- Write sampled at the rising edge in RUN; `word_count`/`last_data`/`checksum` updated the following cycle; `done` rises with the same edge that registers the final word.
- Timeout: ERR entered at the edge ending RUN cycle `TIMEOUT`. Final accepted write in that same cycle wins (DONE).
- `sw` changes after LATCH have no effect on the current job.

## Configuration
- `SEQ_CHECKSUM_EN` defined: `checksum` accumulates accepted words as above.
- Not defined: `checksum` tied to 0, no accumulator logic; all else identical.

## Test plan
- NEG: sw4=1, sw5=0, pulse start; model core writes 67,65,83,65 to addrs 1–4 -> `done`=1, `word_count`=4, `last_data`=65, `checksum`=24 (280 mod 256) with macro.
- XOR 000: writes 76,73,66,82,79 to 9–13 -> `done`=1, `word_count`=5, `mode`=0, `key`=0; `cpu_reset` low exactly from k+2+`HOLD_CYCLES` to DONE.
- Bad switches: sw4=1, sw5=1 -> ERR two cycles after `start_pulse`, `cpu_reset` never drops; XOR key 111 -> same.
- SUM with writes to 5, 7 -> `error`=1 after addr 7; writes to addrs 0, 30 in RUN ignored.
- Timeout: XOR 100, only 3 words to 18–20 -> `error`=1 at RUN cycle 300; final write in cycle 300 -> `done` instead.
- `reset` low during RUN -> all outputs to reset values immediately; new start then completes normally.
